spi_burst_sequencer: RTL and testbench

//  Upstream feeder for the simple_spi byte master. Host writes TX bytes into an internal TX FIFO, then

---
 rtl/spi_burst_sequencer.sv | 174 +++++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_sequencer.sv
// Burst feeder for a byte-wide SPI master: TX FIFO -> SPI handshake -> RX FIFO.
// Host preloads TX words, then a burst command moves len words through the master.
module spi_burst_sequencer #(
  parameter int DATA_N_BIT = 8,
  parameter int N_SLAVES   = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 16,
  localparam int SLV_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1),
  localparam int LEN_W = $clog2(MAX_BURST + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_async_rst,
  input  logic [DATA_N_BIT-1:0] i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic                  i_start,
  input  logic [LEN_W-1:0]      i_burst_len,
  input  logic [SLV_W-1:0]      i_slave_num,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_start_err,
  output logic [DATA_N_BIT-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [LVL_W-1:0]      o_tx_level,
  output logic [LVL_W-1:0]      o_rx_level,
  output logic                  o_rx_overflow,
  output logic [SLV_W-1:0]      o_spi_slave_num,
  output logic [DATA_N_BIT-1:0] o_spi_tx_data,
  output logic                  o_spi_tx_data_valid,
  input  logic                  i_spi_tx_ready,
  input  logic [DATA_N_BIT-1:0] i_spi_rx_data,
  input  logic                  i_spi_rx_data_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_N_BIT-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_N_BIT-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LVL_W-1:0]      tx_lvl, rx_lvl;
  logic [LEN_W-1:0]      rem;

  logic cmd_ok, accept, reject;
  logic tx_push, tx_pop, rx_cap, rx_push, rx_pop, rx_full;

  assign cmd_ok = (i_burst_len != '0)
               && (32'(i_burst_len) <= MAX_BURST)
               && (32'(tx_lvl) >= 32'(i_burst_len));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    tx_pop   = 1'b0;
    rx_cap   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (cmd_ok) begin
            accept   = 1'b1;
            state_nx = ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (i_spi_tx_ready) begin
          tx_pop   = 1'b1;
          state_nx = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (i_spi_rx_data_valid) begin
          rx_cap   = 1'b1;
          state_nx = (rem == LEN_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state           <= IDLE;
      rem             <= '0;
      o_spi_slave_num <= '0;
      o_start_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      o_start_err <= reject;
      if (accept) begin
        rem             <= i_burst_len;
        o_spi_slave_num <= i_slave_num;
      end else if (rx_cap) begin
        rem <= rem - LEN_W'(1);
      end
    end
  end

  // TX FIFO: host pushes, the ISSUE handshake pops
  assign o_wr_ready = (tx_lvl != LVL_W'(FIFO_DEPTH));
  assign tx_push    = i_wr_valid && o_wr_ready;

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wp] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_lvl <= tx_lvl + LVL_W'(1);
        2'b01:   tx_lvl <= tx_lvl - LVL_W'(1);
        default: tx_lvl <= tx_lvl;
      endcase
    end
  end

  // RX FIFO: a capture into a full FIFO is dropped and flagged
  assign rx_full  = (rx_lvl == LVL_W'(FIFO_DEPTH));
  assign rx_push  = rx_cap && !rx_full;
  assign rx_pop   = o_rd_valid && i_rd_ready;

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wp] <= i_spi_rx_data;
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      rx_wp         <= '0;
      rx_rp         <= '0;
      rx_lvl        <= '0;
      o_rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_cap && rx_full) o_rx_overflow <= 1'b1;
      unique case ({rx_push, rx_pop})
        2'b10:   rx_lvl <= rx_lvl + LVL_W'(1);
        2'b01:   rx_lvl <= rx_lvl - LVL_W'(1);
        default: rx_lvl <= rx_lvl;
      endcase
    end
  end

  // data outputs are gated so nothing uninitialised leaks out of the RAMs
  assign o_rd_valid          = (rx_lvl != '0);
  assign o_rd_data           = o_rd_valid ? rx_mem[rx_rp] : '0;
  assign o_spi_tx_data_valid = (state == ISSUE);
  assign o_spi_tx_data       = o_spi_tx_data_valid ? tx_mem[tx_rp] : '0;
  assign o_busy              = (state != IDLE);
  assign o_done              = (state == DONE);
  assign o_tx_level          = tx_lvl;
  assign o_rx_level          = rx_lvl;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer: an SPI slave model returns ~tx,
// monitors pop expected TX words and RX reads from queues filled by the stimulus.
module tb_spi_burst_sequencer;

  localparam int DW = 8;
  localparam int NS = 2;
  localparam int FD = 16;
  localparam int MB = 16;
  localparam int SW = 1;
  localparam int LW = 5;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          start = 1'b0;
  logic [NW-1:0] burst_len = '0;
  logic [SW-1:0] slave_num = '0;
  logic          busy, done, start_err;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [LW-1:0] tx_level, rx_level;
  logic          rx_overflow;
  logic [SW-1:0] spi_slave_num;
  logic [DW-1:0] spi_tx_data;
  logic          spi_tx_valid;
  logic          spi_tx_ready = 1'b0;
  logic [DW-1:0] spi_rx_data = '0;
  logic          spi_rx_valid = 1'b0;

  spi_burst_sequencer #(
    .DATA_N_BIT(DW), .N_SLAVES(NS), .FIFO_DEPTH(FD), .MAX_BURST(MB)
  ) dut (
    .i_clk(clk), .i_async_rst(rst),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_start(start), .i_burst_len(burst_len), .i_slave_num(slave_num),
    .o_busy(busy), .o_done(done), .o_start_err(start_err),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_tx_level(tx_level), .o_rx_level(rx_level),
    .o_rx_overflow(rx_overflow), .o_spi_slave_num(spi_slave_num),
    .o_spi_tx_data(spi_tx_data), .o_spi_tx_data_valid(spi_tx_valid),
    .i_spi_tx_ready(spi_tx_ready), .i_spi_rx_data(spi_rx_data),
    .i_spi_rx_data_valid(spi_rx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit rd_en = 1'b0;
  logic [DW-1:0] exp_tx [$];
  logic [DW-1:0] exp_rd [$];
  logic [DW-1:0] tx_model [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected expected=event", name);
  endtask

  // SPI slave model and TX-side monitor
  initial begin : spi_model
    int pend;
    logic [DW-1:0] cap;
    pend = 0;
    cap  = '0;
    forever begin
      @(negedge clk);
      spi_tx_ready = 1'b0;
      spi_rx_valid = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          spi_rx_valid = 1'b1;
          spi_rx_data  = ~cap;
        end
      end else if (spi_tx_valid) begin
        spi_tx_ready = 1'b1;
        cap  = spi_tx_data;
        pend = 3;
        if (exp_tx.size() == 0) fail_now("spi_tx_unexpected");
        else chk("spi_tx_word", spi_tx_data, exp_tx.pop_front());
      end
    end
  end

  // host read monitor
  initial begin : rd_mon
    forever begin
      @(negedge clk);
      rd_ready = 1'b0;
      if (!rst && rd_en && rd_valid) begin
        rd_ready = 1'b1;
        if (exp_rd.size() == 0) fail_now("rd_unexpected");
        else chk("rd_word", rd_data, exp_rd.pop_front());
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  task automatic wr(input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    if (wr_ready) begin
      exp_tx.push_back(d);
      tx_model.push_back(d);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    fail_now("burst_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_rd.size() == 0) break;
      @(negedge clk);
    end
    chk("rd_drained", exp_rd.size(), 0);
    @(negedge clk);
  endtask

  // keep = how many captured words are expected to land in the RX FIFO
  task automatic burst(input int len, input int slv, input int keep);
    int d0;
    logic [DW-1:0] w;
    d0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      w = tx_model.pop_front();
      if (i < keep) exp_rd.push_back(~w);
    end
    start     = 1'b1;
    burst_len = NW'(len);
    slave_num = SW'(slv);
    @(negedge clk);
    start = 1'b0;
    chk("first_valid_latency", spi_tx_valid, 1);
    chk("slave_latched", spi_slave_num, slv);
    wait_idle();
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic bad_start(input int len);
    start     = 1'b1;
    burst_len = NW'(len);
    @(negedge clk);
    start = 1'b0;
    chk("start_err_pulse", start_err, 1);
    chk("rej_no_valid", spi_tx_valid, 0);
    @(negedge clk);
    chk("start_err_1cyc", start_err, 0);
    chk("rej_not_busy", busy, 0);
    chk("rej_tx_level", tx_level, 2);
  endtask

  initial begin : stim
    int d0;
    // 1: reset state
    #3;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_spi_slave", spi_slave_num, 0);
    chk("rst_spi_data", spi_tx_data, 0);
    chk("rst_spi_valid", spi_tx_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", busy, 0);

    // 2: basic 3-word burst
    rd_en = 1'b1;
    wr(8'h21);
    wr(8'h42);
    wr(8'h84);
    chk("t2_tx_level", tx_level, 3);
    burst(3, 0, 3);
    chk("t2_tx_empty", tx_level, 0);
    chk("t2_tx_all_sent", exp_tx.size(), 0);
    wait_drain();

    // 3: rejected commands
    wr(8'hA1);
    wr(8'hA2);
    bad_start(4);
    bad_start(0);
    burst(2, 0, 2);
    wait_drain();

    // 4: TX full, refused write, push during pop
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    chk("t4_level_full", tx_level, 16);
    chk("t4_wr_ready_full", wr_ready, 0);
    wr(8'hEE);
    chk("t4_refused", tx_level, 16);
    burst(1, 1, 1);
    chk("t4_level_15", tx_level, 15);
    exp_rd.push_back(~tx_model.pop_front());
    start     = 1'b1;
    burst_len = NW'(1);
    slave_num = '0;
    @(negedge clk);
    start = 1'b0;
    chk("t4_issue", spi_tx_valid, 1);
    wr(8'h5A);
    chk("t4_push_pop_level", tx_level, 15);
    wait_idle();
    wait_drain();

    // 5: RX overflow
    rd_en = 1'b0;
    burst(15, 0, 15);
    wr(8'hE1);
    wr(8'hE2);
    wr(8'hE3);
    burst(1, 0, 1);
    chk("t5_rx_full", rx_level, 16);
    chk("t5_no_ovf_yet", rx_overflow, 0);
    burst(2, 0, 0);
    chk("t5_overflow", rx_overflow, 1);
    chk("t5_rx_still_16", rx_level, 16);
    rd_en = 1'b1;
    wait_drain();
    chk("t5_rx_empty", rx_level, 0);
    chk("t5_ovf_sticky", rx_overflow, 1);
    chk("t5_tx_empty", tx_level, 0);

    // 6: reset mid-burst
    rd_en = 1'b0;
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    start     = 1'b1;
    burst_len = NW'(3);
    @(negedge clk);
    start = 1'b0;
    begin : find_wait
      for (int i = 0; i < 50; i++) begin
        if (busy && !spi_tx_valid) disable find_wait;
        @(negedge clk);
      end
      fail_now("t6_no_wait_rx");
    end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_async", spi_tx_valid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_tx_level", tx_level, 0);
    chk("t6_rx_level", rx_level, 0);
    chk("t6_ovf_cleared", rx_overflow, 0);
    exp_tx.delete();
    tx_model.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_idle", busy, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_rd_valid", rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
